kbd_event_decoder: RTL and testbench

- Sits between the PS/2 keyboard receiver (ps2_kbd) and the CPU keyboard MMIO read path.
- Pops raw scancode bytes from the receiver and parses set-2 prefixes (E0 = extended, F0 = break).
- Tracks shift, ctrl and caps-lock state and translates to ASCII.
- Queues one 32-bit key-event word per key transition in an event FIFO, which the CPU pops with a read strobe.

---
 rtl/kbd_event_decoder_if.sv | 25 ++
 rtl/kbd_event_decoder.sv | 197 +++++++++++++++++++
 tb/tb_kbd_event_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_event_decoder_if.sv
// Bus bundle between the keyboard event decoder, the PS/2 receiver and the CPU read path.
// The master drives the receiver head byte and the CPU strobes; the slave is the decoder.
interface kbd_event_decoder_if #(
    parameter int PTR_W = 3
);
    logic [7:0]     kbd_data;
    logic           kbd_ready;
    logic           kbd_rdn;
    logic           ev_rd;
    logic           ev_valid;
    logic [31:0]    ev_data;
    logic [PTR_W:0] ev_count;
    logic           ev_overflow;
    logic           ovf_clr;

    modport master (
        output kbd_data, kbd_ready, ev_rd, ovf_clr,
        input  kbd_rdn, ev_valid, ev_data, ev_count, ev_overflow
    );

    modport slave (
        input  kbd_data, kbd_ready, ev_rd, ovf_clr,
        output kbd_rdn, ev_valid, ev_data, ev_count, ev_overflow
    );
endinterface

// File: rtl/kbd_event_decoder.sv
// Set-2 scancode parser: pops receiver bytes, tracks modifiers, translates to ASCII and
// queues one 32-bit key-event word per key transition for the CPU.
//
// state  | meaning
// F_IDLE | waiting for a receiver byte; pops it when ready
// F_WAIT | popped byte is presented to the parser for one cycle
// P_IDLE | no prefix seen
// P_E0   | extended prefix seen
// P_F0   | break prefix seen
// P_E0F0 | extended break prefix seen
module kbd_event_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    kbd_event_decoder_if.slave   bus
);
    typedef enum logic       {F_IDLE, F_WAIT} fetch_e;
    typedef enum logic [1:0] {P_IDLE, P_E0, P_F0, P_E0F0} parse_e;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    fetch_e           f_q, f_d;
    parse_e           p_q, p_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_vld, kbd_rdn_c;
    logic             shift_q, shift_d, ctrl_q, ctrl_d, caps_q, caps_d, held_q, held_d;
    logic             emit, brk, ext;
    logic [7:0]       ascii;
    logic [31:0]      ev_word;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             pop, full, push_ok, drop;

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic sh,
                                            input logic upper);
        logic [7:0] a;
        logic       letter;
        a      = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
            8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
            8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
            8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
            8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
            8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
            8'h35: a = "y";  8'h1A: a = "z";
            default: letter = 1'b0;
        endcase
        if (letter) begin
            if (upper) a = a - 8'h20;
        end else begin
            case (code)
                8'h16: a = sh ? "!" : "1";
                8'h1E: a = sh ? "@" : "2";
                8'h26: a = sh ? "#" : "3";
                8'h25: a = sh ? "$" : "4";
                8'h2E: a = sh ? "%" : "5";
                8'h36: a = sh ? "^" : "6";
                8'h3D: a = sh ? "&" : "7";
                8'h3E: a = sh ? "*" : "8";
                8'h46: a = sh ? "(" : "9";
                8'h45: a = sh ? ")" : "0";
                8'h29: a = 8'h20;
                8'h5A: a = 8'h0A;
                8'h66: a = 8'h08;
                8'h0D: a = 8'h09;
                8'h76: a = 8'h1B;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q      <= F_IDLE;
            p_q      <= P_IDLE;
            byte_q   <= '0;
            shift_q  <= 1'b0;
            ctrl_q   <= 1'b0;
            caps_q   <= 1'b0;
            held_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            f_q      <= f_d;
            p_q      <= p_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            ctrl_q   <= ctrl_d;
            caps_q   <= caps_d;
            held_q   <= held_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ready is ignored in F_WAIT, so the receiver gets a cycle to advance its head byte
    always_comb begin
        f_d       = f_q;
        byte_d    = byte_q;
        kbd_rdn_c = 1'b1;
        byte_vld  = 1'b0;
        case (f_q)
            F_IDLE: begin
                if (bus.kbd_ready && !rst) begin
                    byte_d    = bus.kbd_data;
                    kbd_rdn_c = 1'b0;
                    f_d       = F_WAIT;
                end
            end
            F_WAIT: begin
                byte_vld = 1'b1;
                f_d      = F_IDLE;
            end
            default: f_d = F_IDLE;
        endcase
    end

    always_comb begin
        p_d     = p_q;
        emit    = 1'b0;
        shift_d = shift_q;
        ctrl_d  = ctrl_q;
        caps_d  = caps_q;
        held_d  = held_q;
        brk     = (p_q == P_F0) || (p_q == P_E0F0);
        ext     = (p_q == P_E0) || (p_q == P_E0F0);
        if (byte_vld) begin
            case (p_q)
                P_IDLE: begin
                    if (byte_q == 8'hE0)      p_d = P_E0;
                    else if (byte_q == 8'hF0) p_d = P_F0;
                    else if (!(byte_q inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) emit = 1'b1;
                end
                P_E0: begin
                    if (byte_q == 8'hF0)      p_d = P_E0F0;
                    else if (byte_q != 8'hE0) emit = 1'b1;
                end
                default: emit = 1'b1;
            endcase
        end
        if (emit) begin
            p_d = P_IDLE;
            if (!ext && (byte_q == 8'h12 || byte_q == 8'h59)) shift_d = !brk;
            if (byte_q == 8'h14) ctrl_d = !brk;
            if (!ext && byte_q == 8'h58) begin
                if (!brk) begin
                    if (!held_q) caps_d = !caps_q;
                    held_d = 1'b1;
                end else begin
                    held_d = 1'b0;
                end
            end
        end
        ascii   = ext ? 8'h00 : ascii_of(byte_q, shift_d, shift_d ^ caps_d);
        ev_word = {11'd0, caps_d, ctrl_d, shift_d, ext, brk, byte_q, ascii};
    end

    assign pop     = bus.ev_rd && (count_q != '0);
    assign full    = (count_q == DEPTH_C);
    assign push_ok = emit && (!full || pop);
    assign drop    = emit && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= ev_word;
    end

    // a drop in the same cycle as ovf_clr keeps the flag set
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (!push_ok && pop) count_d = count_q - (PTR_W+1)'(1);
        if (drop)             ovf_d = 1'b1;
        else if (bus.ovf_clr) ovf_d = 1'b0;
    end

    assign bus.kbd_rdn     = kbd_rdn_c;
    assign bus.ev_valid    = (count_q != '0);
    assign bus.ev_data     = mem_q[rd_ptr_q];
    assign bus.ev_count    = count_q;
    assign bus.ev_overflow = ovf_q;
endmodule

// File: tb/tb_kbd_event_decoder.sv
// Bench for kbd_event_decoder: a byte-source model feeds the decoder while a flag-based
// scancode model predicts the event words.
module tb_kbd_event_decoder;
    logic clk = 1'b0;
    logic rst;
    kbd_event_decoder_if #(.PTR_W(3)) bus ();

    kbd_event_decoder #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  src_q[$];
    logic [31:0] exp_q[$];
    bit          pop_pend = 0;
    int          pop_cnt = 0;
    int          neg_cnt = 0;
    int          last_pop_neg = 0;

    bit m_ext, m_brk, m_shift, m_ctrl, m_caps, m_held;
    logic [7:0] asc_lo [256];
    logic [7:0] asc_hi [256];
    bit         is_letter [256];
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h45};
    logic [7:0] mod_codes [4]  = '{8'h12, 8'h59, 8'h14, 8'h58};
    logic [7:0] spec_codes [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] spec_vals [5]  = '{8'h20, 8'h0A, 8'h08, 8'h09, 8'h1B};

    // receiver model: holds the head byte until the decoder pulls kbd_rdn low
    initial begin
        bus.kbd_ready = 1'b0;
        bus.kbd_data  = 8'h00;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (pop_pend) begin
                void'(src_q.pop_front());
                pop_pend = 0;
            end
            bus.kbd_ready = (src_q.size() > 0);
            bus.kbd_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
            #1;
            if (!bus.kbd_rdn) begin
                pop_pend     = 1;
                pop_cnt++;
                last_pop_neg = neg_cnt;
            end
        end
    end

    task automatic build_tables();
        string dig  = "1234567890";
        string sdig = "!@#$%^&*()";
        for (int i = 0; i < 256; i++) begin
            asc_lo[i] = 8'h00; asc_hi[i] = 8'h00; is_letter[i] = 0;
        end
        for (int i = 0; i < 26; i++) begin
            asc_lo[letter_codes[i]]    = 8'h61 + 8'(i);
            asc_hi[letter_codes[i]]    = 8'h41 + 8'(i);
            is_letter[letter_codes[i]] = 1;
        end
        for (int i = 0; i < 10; i++) begin
            asc_lo[digit_codes[i]] = dig[i];
            asc_hi[digit_codes[i]] = sdig[i];
        end
        for (int i = 0; i < 5; i++) begin
            asc_lo[spec_codes[i]] = spec_vals[i];
            asc_hi[spec_codes[i]] = spec_vals[i];
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_shift = 0; m_ctrl = 0; m_caps = 0; m_held = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] a;
        if (!m_brk) begin
            if (b == 8'hE0) begin m_ext = 1; return; end
            if (b == 8'hF0) begin m_brk = 1; return; end
            if (!m_ext && (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF))
                return;
        end
        if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
        if (b == 8'h14) m_ctrl = !m_brk;
        if (!m_ext && b == 8'h58) begin
            if (!m_brk && !m_held) m_caps = !m_caps;
            m_held = !m_brk;
        end
        if (m_ext)              a = 8'h00;
        else if (is_letter[b])  a = (m_shift ^ m_caps) ? asc_hi[b] : asc_lo[b];
        else                    a = m_shift ? asc_hi[b] : asc_lo[b];
        exp_q.push_back({11'd0, m_caps, m_ctrl, m_shift, m_ext, m_brk, b, a});
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic feed(input logic [7:0] b);
        src_q.push_back(b);
        model_byte(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((src_q.size() != 0 || pop_pend) && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL wait_idle: source still holds %0d bytes, want 0", src_q.size());
        end
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic read_ev(output logic [31:0] d);
        @(negedge clk);
        #2;
        d = bus.ev_data;
        bus.ev_rd = 1'b1;
        @(negedge clk);
        bus.ev_rd = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        total++; if (bus.kbd_rdn !== 1'b1)     begin bad++; $display("FAIL reset_rdn: got %b want 1", bus.kbd_rdn); end
        total++; if (bus.ev_valid !== 1'b0)    begin bad++; $display("FAIL reset_valid: got %b want 0", bus.ev_valid); end
        total++; if (bus.ev_count !== 4'd0)    begin bad++; $display("FAIL reset_count: got %0d want 0", bus.ev_count); end
        total++; if (bus.ev_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.ev_overflow); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        int p0 = pop_cnt;
        int nv = -1;
        logic [31:0] d;
        feed(8'h1C);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (bus.ev_valid === 1'b1) begin nv = neg_cnt; break; end
        end
        total++; if (nv < 0) begin bad++; $display("FAIL single_valid: ev_valid never rose, want 1"); end
        total++; if (nv - last_pop_neg != 2) begin bad++; $display("FAIL single_latency: got %0d cycles want 2", nv - last_pop_neg); end
        total++; if (bus.ev_data !== 32'h0000_1C61) begin bad++; $display("FAIL single_data: got %h want 00001c61", bus.ev_data); end
        wait_idle();
        total++; if (pop_cnt - p0 != 1) begin bad++; $display("FAIL single_rdn: got %0d pops want 1", pop_cnt - p0); end
        total++; if (bus.ev_count !== 4'd1) begin bad++; $display("FAIL single_count: got %0d want 1", bus.ev_count); end
        read_ev(d);
        void'(exp_q.pop_front());
        total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL single_rd_valid: got %b want 0", bus.ev_valid); end
        total++; if (bus.ev_count !== 4'd0) begin bad++; $display("FAIL single_rd_count: got %0d want 0", bus.ev_count); end
    endtask

    task automatic test_shift();
        logic [31:0] lit [4] = '{32'h0004_1200, 32'h0004_1C41, 32'h0005_1C41, 32'h0001_1200};
        logic [7:0]  seq [6] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
        logic [31:0] d;
        foreach (seq[i]) feed(seq[i]);
        wait_idle();
        total++; if (bus.ev_count !== 4'd4) begin bad++; $display("FAIL shift_count: got %0d want 4", bus.ev_count); end
        for (int i = 0; i < 4; i++) begin
            read_ev(d);
            void'(exp_q.pop_front());
            total++; if (d !== lit[i]) begin bad++; $display("FAIL shift_ev%0d: got %h want %h", i, d, lit[i]); end
        end
    endtask

    task automatic test_ext();
        logic [31:0] lit [4] = '{32'h0002_7500, 32'h0003_7500, 32'h000A_1400, 32'h0003_1400};
        logic [7:0]  seq [10] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h14, 8'hE0, 8'hF0, 8'h14};
        logic [31:0] d;
        foreach (seq[i]) feed(seq[i]);
        wait_idle();
        total++; if (bus.ev_count !== 4'd4) begin bad++; $display("FAIL ext_count: got %0d want 4", bus.ev_count); end
        for (int i = 0; i < 4; i++) begin
            read_ev(d);
            void'(exp_q.pop_front());
            total++; if (d !== lit[i]) begin bad++; $display("FAIL ext_ev%0d: got %h want %h", i, d, lit[i]); end
        end
    endtask

    task automatic test_caps();
        logic [31:0] lit [7] = '{32'h0010_5800, 32'h0010_5800, 32'h0010_5800, 32'h0011_5800,
                                 32'h0010_1C41, 32'h0000_5800, 32'h0001_5800};
        logic [7:0]  seq [9] = '{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C, 8'h58, 8'hF0, 8'h58};
        logic [31:0] d;
        foreach (seq[i]) feed(seq[i]);
        wait_idle();
        total++; if (bus.ev_count !== 4'd7) begin bad++; $display("FAIL caps_count: got %0d want 7", bus.ev_count); end
        for (int i = 0; i < 7; i++) begin
            read_ev(d);
            void'(exp_q.pop_front());
            total++; if (d !== lit[i]) begin bad++; $display("FAIL caps_ev%0d: got %h want %h", i, d, lit[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic [7:0]  code;
        int          pre;
        for (int it = 0; it < 25; it++) begin
            int nkeys = $urandom_range(1, 6);
            for (int k = 0; k < nkeys; k++) begin
                case ($urandom_range(0, 4))
                    0: code = letter_codes[$urandom_range(0, 25)];
                    1: code = digit_codes[$urandom_range(0, 9)];
                    2: code = mod_codes[$urandom_range(0, 3)];
                    3: code = spec_codes[$urandom_range(0, 4)];
                    default: begin
                        code = 8'($urandom_range(0, 255));
                        if (code == 8'hE0 || code == 8'hF0) code = 8'h11;
                    end
                endcase
                pre = $urandom_range(0, 3);
                if (code == 8'h58 && pre >= 2) pre = pre - 2;
                if ($urandom_range(0, 7) == 0) feed(8'hAA);
                if (pre >= 2) feed(8'hE0);
                if (pre == 1 || pre == 3) feed(8'hF0);
                feed(code);
            end
            wait_idle();
            total++;
            if (bus.ev_count !== 4'(exp_q.size())) begin
                bad++; $display("FAIL rand_count it%0d: got %0d want %0d", it, bus.ev_count, exp_q.size());
            end
            while (exp_q.size() > 0) begin
                read_ev(d);
                e = exp_q.pop_front();
                total++; if (d !== e) begin bad++; $display("FAIL rand_ev it%0d: got %h want %h", it, d, e); end
            end
            total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL rand_empty it%0d: got %b want 0", it, bus.ev_valid); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int p0, seen;
        do_reset();
        for (int i = 0; i < 9; i++) feed(8'h16);
        wait_idle();
        exp_q.delete();
        total++; if (bus.ev_count !== 4'd8)          begin bad++; $display("FAIL ovf_count: got %0d want 8", bus.ev_count); end
        total++; if (bus.ev_overflow !== 1'b1)       begin bad++; $display("FAIL ovf_flag: got %b want 1", bus.ev_overflow); end
        total++; if (bus.ev_data !== 32'h0000_1631) begin bad++; $display("FAIL ovf_head: got %h want 00001631", bus.ev_data); end
        // line up ev_rd with the cycle the new event is pushed
        p0 = pop_cnt;
        seen = 0;
        feed(8'h16);
        exp_q.delete();
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (pop_cnt != p0) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL ovf_pop_wait: no pop seen, want 1"); end
        @(negedge clk);
        bus.ev_rd = 1'b1;
        @(negedge clk);
        bus.ev_rd = 1'b0;
        wait_idle();
        total++; if (bus.ev_count !== 4'd8) begin bad++; $display("FAIL ovf_rdpush_count: got %0d want 8", bus.ev_count); end
        @(negedge clk);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        #2;
        total++; if (bus.ev_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", bus.ev_overflow); end
        for (int i = 0; i < 8; i++) begin
            read_ev(d);
            total++; if (d !== 32'h0000_1631) begin bad++; $display("FAIL ovf_drain%0d: got %h want 00001631", i, d); end
        end
        total++; if (bus.ev_count !== 4'd0) begin bad++; $display("FAIL ovf_drain_count: got %0d want 0", bus.ev_count); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] d;
        do_reset();
        feed(8'hE0);
        wait_idle();
        total++; if (bus.ev_count !== 4'd0) begin bad++; $display("FAIL rstmid_prefix: got %0d want 0", bus.ev_count); end
        do_reset();
        feed(8'h75);
        wait_idle();
        total++; if (bus.ev_count !== 4'd1) begin bad++; $display("FAIL rstmid_count: got %0d want 1", bus.ev_count); end
        read_ev(d);
        void'(exp_q.pop_front());
        total++; if (d !== 32'h0000_7500) begin bad++; $display("FAIL rstmid_ev: got %h want 00007500", d); end
        feed(8'hAA);
        feed(8'hFA);
        wait_idle();
        total++; if (bus.ev_count !== 4'd0) begin bad++; $display("FAIL discard_count: got %0d want 0", bus.ev_count); end
        total++; if (bus.ev_valid !== 1'b0) begin bad++; $display("FAIL discard_valid: got %b want 0", bus.ev_valid); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.ev_rd   = 1'b0;
        bus.ovf_clr = 1'b0;
        build_tables();
        test_reset();
        test_single();
        test_shift();
        test_ext();
        test_caps();
        test_random();
        test_overflow();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
